axi4_lite_master_seq: RTL and testbench
=======================================

# axi4_lite_master_seq

AXI4-Lite initiator that turns a simple command/response stream into single AXI4-Lite write and read transactions, one outstanding at a time. It sits between a loader or test sequencer and the LSTM register slave. The sequencer uses it to program weights and biases, write C/h/x inputs and poll y_out/C_out/version. It also counts error responses for debug.

## Interface
- ADDR_WIDTH, 32: AXI address width; commands carry the full byte address.
- DATA_WIDTH, 32: AXI data width; fixed at 32 for AXI4-Lite.
- ERR_CNT_WIDTH, 16: width of the saturating error counter.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  captured bresp/rresp.
- err_count  out  ERR_CNT_WIDTH  number of non-OKAY responses, saturating.
- busy  out  1  high whenever state is not IDLE.
- AXI master ports, standard directions: awaddr[31:0], awprot[2:0], awvalid, awready, wdata[31:0], wstrb[3:0], wvalid, wready, bresp[1:0], bvalid, bready, araddr[31:0], arprot[2:0], arvalid, arready, rdata[31:0], rresp[1:0], rvalid, rready.

## Operation
- States:
  - IDLE: cmd_ready = 1.
  - WADDR_DATA: awvalid/wvalid pending.
  - WRESP: bready = 1.
  - RADDR: arvalid = 1.
  - RDATA: rready = 1.
  - RESP: rsp_valid = 1.
- IDLE + cmd_valid: register addr/data/write, go to WADDR_DATA (write) or RADDR (read).
- WADDR_DATA: awvalid and wvalid both rise together.
  - Each drops independently on its own handshake; aw_done/w_done flags track completion.
  - Go to WRESP in the cycle after both are done. This includes the case where both handshake in the same cycle.
- bready stays low until WRESP, so bvalid arriving early is held by the slave, per protocol.
- WRESP + bvalid: capture bresp, set rsp_data = 0, go to RESP.
- RADDR + arready: go to RDATA. RDATA + rvalid: capture rdata/rresp, go to RESP.
- RESP + rsp_ready: go to IDLE. rsp_* stay stable while rsp_valid is high and rsp_ready is low.
- awprot = arprot = 3'b000; wstrb = 4'hF. awaddr/araddr/wdata are driven from registers and are stable while valid is high.
- err_count increments by 1 on any captured resp != 2'b00 and saturates at all-ones.
- Reset values:
  - All valid/ready outputs 0 and cmd_ready 0 during rst; cmd_ready is 1 from the first cycle after rst deasserts.
  - rsp_* 0, err_count 0, busy 0, state IDLE.
  - AXI address/data outputs 0.
- Reset mid-transaction: return to IDLE at the next edge, drop all valids and abandon the transaction with no response. The connected slave is reset by the same rst.

## Timing
- All AXI outputs are registered; no combinational path from AXI inputs to AXI outputs.
- cmd_ready = (state == IDLE), combinational from state only.
- Zero-wait write, command accepted at edge 0:
  - awvalid/wvalid high cycle 1, handshake in cycle 1.
  - bready high cycle 2, bvalid accepted in cycle 2.
  - rsp_valid high cycle 3.
- Zero-wait read: arvalid cycle 1, rready cycle 2, rsp_valid cycle 3.
- Throughput: at most one transaction per 4 cycles.
- A new command can be accepted in the cycle after rsp_valid && rsp_ready.

## Structure
- Shared package axi4_lite_pkg holds:
  - the state enum typedef;
  - resp constants: RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - DEFAULT_PROT = 3'b000 and FULL_STRB = 4'hF.
- LSTM register offsets (weight/bias/C/h/x blocks, Y_OUT, C_OUT, VERSION) go in the same package so sequencers and benches share them.
- Single flat module; no sub-module is needed.

## Test plan
- Zero-wait write, addr 0x40, data 0x0000_1234, slave bresp 00 -> awvalid/wvalid in cycle 1, bready in cycle 2, rsp_valid in cycle 3 with rsp_write = 1, rsp_resp = 00, rsp_data = 0.
- Staggered write, awready at cycle 1, wready 3 cycles later -> awvalid drops after cycle 1, wvalid held through cycle 4, bready first high in cycle 5.
- Read addr 0x110, slave returns rdata 0xDEAD_BEEF, rresp 00 after 2 wait cycles -> rsp_data = 0xDEAD_BEEF, rsp_write = 0, err_count unchanged.
- Slave bresp 2'b10 -> rsp_resp = 10 and err_count goes 0 -> 1. Preloaded at 0xFFFF, a further error leaves it at 0xFFFF.
- rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready = 0, no AXI activity; IDLE on the cycle after rsp_ready rises.
- rst asserted while in WRESP -> next cycle all valids 0, busy 0, no rsp_valid. A following write to 0x40 completes normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: initiator state encoding, response codes and
// the LSTM register map used by sequencers and benches.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaddrData,
    StWresp,
    StRaddr,
    StRdata,
    StResp
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] DEFAULT_PROT = 3'b000;
  localparam logic [3:0] FULL_STRB    = 4'hF;

  // LSTM register slave byte offsets
  localparam logic [31:0] LSTM_WEIGHT_BASE = 32'h0000_0000;
  localparam logic [31:0] LSTM_BIAS_BASE   = 32'h0000_0100;
  localparam logic [31:0] LSTM_C_IN_BASE   = 32'h0000_0200;
  localparam logic [31:0] LSTM_H_IN_BASE   = 32'h0000_0280;
  localparam logic [31:0] LSTM_X_IN_BASE   = 32'h0000_0300;
  localparam logic [31:0] LSTM_Y_OUT       = 32'h0000_0400;
  localparam logic [31:0] LSTM_C_OUT       = 32'h0000_0404;
  localparam logic [31:0] LSTM_VERSION     = 32'h0000_04FC;

endpackage

// File: rtl/axi4_lite_master_seq_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4_lite_master_seq_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_master_seq.sv
// Command/response to AXI4-Lite initiator, one transaction outstanding, with a
// saturating count of non-OKAY responses.
module axi4_lite_master_seq
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [1:0]               rsp_resp,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     busy,
  axi4_lite_master_seq_if.master   axi
);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;
  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     bready_q, bready_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic [1:0]               rsp_resp_q, rsp_resp_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     resp_capture;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    rsp_write_d  = rsp_write_q;
    rsp_data_d   = rsp_data_q;
    rsp_resp_d   = rsp_resp_q;
    err_cnt_d    = err_cnt_q;
    resp_capture = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWaddrData : StRaddr;
        end
      end
      StWaddrData: begin
        if (awvalid_q && axi.awready) aw_done_d = 1'b1;
        if (wvalid_q && axi.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)    state_d   = StWresp;
      end
      StWresp: begin
        if (axi.bvalid) begin
          rsp_write_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_resp_d   = axi.bresp;
          resp_capture = 1'b1;
          state_d      = StResp;
        end
      end
      StRaddr: begin
        if (axi.arready) state_d = StRdata;
      end
      StRdata: begin
        if (axi.rvalid) begin
          rsp_write_d  = 1'b0;
          rsp_data_d   = axi.rdata;
          rsp_resp_d   = axi.rresp;
          resp_capture = 1'b1;
          state_d      = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (resp_capture && (rsp_resp_d != RESP_OKAY) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
    end

    // Valids/readies are decoded from the next state so every AXI output is a flop.
    awvalid_d   = (state_d == StWaddrData) && !aw_done_d;
    wvalid_d    = (state_d == StWaddrData) && !w_done_d;
    bready_d    = (state_d == StWresp);
    arvalid_d   = (state_d == StRaddr);
    rready_d    = (state_d == StRdata);
    rsp_valid_d = (state_d == StResp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Gated by rst so the command port stays closed while reset is held.
  assign cmd_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q != StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_resp  = rsp_resp_q;
  assign err_count = err_cnt_q;

  assign axi.awaddr  = addr_q;
  assign axi.awprot  = DEFAULT_PROT;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = FULL_STRB;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q;
  assign axi.arprot  = DEFAULT_PROT;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_seq.sv
// Bench for axi4_lite_master_seq: timing-formula slave, response/error-count
// reference model, directed cases followed by randomized transactions.
module tb_axi4_lite_master_seq;
  import axi4_lite_pkg::*;

  localparam int unsigned ERR_W   = 4;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [31:0]       cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_resp;
  logic [ERR_W-1:0]  err_count;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int err_model = 0;

  axi4_lite_master_seq_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axi4_lite_master_seq #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .ERR_CNT_WIDTH(ERR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_data(rsp_data),
    .rsp_resp(rsp_resp),
    .err_count(err_count),
    .busy(busy),
    .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle_slave();
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rresp   = 2'b00;
    axi.rdata   = '0;
  endtask

  function automatic logic [7:0] ctl_now();
    return {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready,
            rsp_valid, cmd_ready, busy};
  endfunction

  // One transaction. Delays are in cycles after the command edge:
  // a_dly = addr handshake wait, w_dly = write data wait, r_dly = B/R wait,
  // hold = cycles rsp_ready stays low once rsp_valid is up.
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int a_dly, input int w_dly, input int r_dly,
                        input logic [1:0] resp, input int hold);
    int          a_hs, w_hs, d_c, b_hs, rsp_c, rdy_c;
    logic [7:0]  exp_ctl;
    logic [31:0] exp_data;
    a_hs     = 1 + a_dly;
    w_hs     = wr ? 1 + w_dly : a_hs;
    d_c      = (a_hs > w_hs) ? a_hs : w_hs;
    b_hs     = d_c + 1 + r_dly;
    rsp_c    = b_hs + 1;
    rdy_c    = rsp_c + hold;
    exp_data = wr ? 32'h0 : data;
    if (resp != RESP_OKAY && err_model < ERR_MAX) err_model++;

    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wr ? data : $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;

    for (int c = 1; c <= rdy_c; c++) begin
      exp_ctl = {wr && (c <= a_hs), wr && (c <= w_hs), wr && (c > d_c) && (c <= b_hs),
                 !wr && (c <= a_hs), !wr && (c > a_hs) && (c <= b_hs),
                 c >= rsp_c, 1'b0, 1'b1};
      check("ctl", 64'(ctl_now()), 64'(exp_ctl));
      if (wr && c <= a_hs) check("awaddr", 64'({axi.awaddr, axi.awprot}), 64'({addr, DEFAULT_PROT}));
      if (wr && c <= w_hs) check("wdata", 64'({axi.wdata, axi.wstrb}), 64'({data, FULL_STRB}));
      if (!wr && c <= a_hs) check("araddr", 64'({axi.araddr, axi.arprot}), 64'({addr, DEFAULT_PROT}));
      if (c >= rsp_c)
        check("rsp", 64'({rsp_write, rsp_resp, err_count, rsp_data}),
              64'({wr, resp, ERR_W'(err_model), exp_data}));

      axi.awready = wr && (c == a_hs);
      axi.wready  = wr && (c == w_hs);
      axi.bvalid  = wr && (c == b_hs);
      axi.bresp   = (wr && c == b_hs) ? resp : 2'($urandom_range(0, 3));
      axi.arready = !wr && (c == a_hs);
      axi.rvalid  = !wr && (c == b_hs);
      axi.rresp   = (!wr && c == b_hs) ? resp : 2'($urandom_range(0, 3));
      axi.rdata   = (!wr && c == b_hs) ? data : $urandom;
      rsp_ready   = (c >= rdy_c) || ((c < rsp_c) && ($urandom_range(0, 1) == 1));
      @(negedge clk);
    end
    idle_slave();
    rsp_ready = 1'b0;
    check("post_idle", 64'({cmd_ready, busy, rsp_valid}), 64'(3'b100));
  endtask

  // Write that is interrupted by rst while waiting on the B channel.
  task automatic reset_in_wresp();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h80;
    cmd_wdata = 32'hCAFE_0001;
    @(negedge clk);
    cmd_valid   = 1'b0;
    axi.awready = 1'b1;
    axi.wready  = 1'b1;
    @(negedge clk);
    check("wresp_ctl", 64'(ctl_now()), 64'(8'b0010_0001));
    idle_slave();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctl", 64'(ctl_now()), 64'(8'b0));
    check("rst_mid_rsp", 64'({rsp_write, rsp_resp, err_count, rsp_data}), 64'(0));
    check("rst_mid_bus", 64'({axi.awaddr, axi.wdata}), 64'(0));
    err_model = 0;
    rst = 1'b0;
    #1;
    check("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] a;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    idle_slave();
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'(ctl_now()), 64'(8'b0));
    check("rst_rsp", 64'({rsp_write, rsp_resp, err_count, rsp_data}), 64'(0));
    check("rst_bus", 64'({axi.awaddr, axi.wdata}), 64'(0));
    check("rst_araddr", 64'(axi.araddr), 64'(0));
    rst = 1'b0;
    #1;
    check("rst_release_cmd_ready", 64'(cmd_ready), 64'(1));
    @(negedge clk);

    do_txn(1'b1, 32'h40, 32'h0000_1234, 0, 0, 0, RESP_OKAY, 0);
    do_txn(1'b1, LSTM_WEIGHT_BASE + 32'h8, 32'h0BAD_F00D, 0, 3, 0, RESP_OKAY, 0);
    do_txn(1'b0, 32'h110, 32'hDEAD_BEEF, 0, 0, 2, RESP_OKAY, 0);
    do_txn(1'b1, LSTM_BIAS_BASE, 32'h1111_2222, 1, 0, 1, RESP_SLVERR, 0);
    do_txn(1'b0, LSTM_VERSION, 32'h0001_0203, 0, 0, 0, RESP_OKAY, 5);
    reset_in_wresp();
    do_txn(1'b1, 32'h40, 32'h0000_5678, 0, 0, 0, RESP_OKAY, 0);

    for (int i = 0; i < 40; i++) begin
      r = ($urandom_range(0, 1) == 1) ? RESP_OKAY : 2'($urandom_range(1, 3));
      a = $urandom & 32'hFFFF_FFFC;
      do_txn($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), r, $urandom_range(0, 3));
    end

    // Drive the counter well past its ceiling.
    for (int i = 0; i < ERR_MAX + 2; i++) begin
      do_txn(i % 2 == 0, LSTM_Y_OUT, $urandom, 0, 1, 0, (i % 3 == 0) ? RESP_DECERR : RESP_SLVERR, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
